// File: rtl/sort_actuator_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sort_actuator_ctrl_pkg
// Shared definitions for the sorting actuator controller: object class
// encoding, LED indicator patterns and FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package sort_actuator_ctrl_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SMALL  = 2'd1,
        CLS_MEDIUM = 2'd2,
        CLS_LARGE  = 2'd3
    } cls_e;

    localparam logic [3:0] LED_NONE   = 4'b0000;
    localparam logic [3:0] LED_SMALL  = 4'b0100;
    localparam logic [3:0] LED_MEDIUM = 4'b0010;
    localparam logic [3:0] LED_LARGE  = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRE     = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    function automatic logic [3:0] led_pattern(input cls_e c);
        case (c)
            CLS_SMALL:  return LED_SMALL;
            CLS_MEDIUM: return LED_MEDIUM;
            CLS_LARGE:  return LED_LARGE;
            default:    return LED_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sort_actuator_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Brings the active-low trigger key into the clk domain (2-FF synchronizer),
// optionally filters it, and emits a one-cycle pulse on the filtered
// high-to-low transition (key press).
//
// Build option: SORT_DEBOUNCE_EN -- when defined, the synchronized key must
// hold a new level for DB_CNT consecutive cycles before the filtered level
// follows it. When undefined the filtered level is the synchronizer output.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   key_n  in   raw key, active low, asynchronous to clk
//   trig   out  one-cycle press pulse
// -----------------------------------------------------------------------------
module key_debounce
    import sort_actuator_ctrl_pkg::*;
#(
    parameter int DB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic trig
);

    if (DB_CNT < 1) begin : g_bad_db_cnt
        $error("key_debounce: DB_CNT must be at least 1");
    end

    logic sync_p0;
    logic sync_p1;
    logic filt;
    logic filt_d;

    // Synchronizer stage; flops come out of reset as "key released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

`ifdef SORT_DEBOUNCE_EN
    localparam int DW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

    logic [DW-1:0] db_cnt;

    // Filter stage: any return to the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt   <= 1'b1;
            db_cnt <= '0;
        end else if (sync_p1 == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DW'(DB_CNT - 1)) begin
            filt   <= sync_p1;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign filt = sync_p1;
`endif

    // Edge detect stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_d <= 1'b1;
        end else begin
            filt_d <= filt;
        end
    end

    assign trig = filt_d & ~filt;

endmodule

// File: rtl/sort_actuator_ctrl.sv
// -----------------------------------------------------------------------------
// sort_actuator_ctrl
// Periodically samples an object-size measure, classifies it as SMALL /
// MEDIUM / LARGE, tracks how many consecutive samples agreed, and on a key
// press fires the actuator belonging to the (stable) class for PULSE_CNT
// cycles followed by an equally long cooldown.
//
// Build option: SORT_DEBOUNCE_EN enables the key debounce filter (DB_CNT).
//
// Ports:
//   clk         in   50 MHz system clock
//   rst_n       in   asynchronous active-low reset
//   answer      in   [10:0] unsigned object-size measure (quasi-static)
//   key_trig    in   sort trigger key, active low, asynchronous
//   led         out  [3:0] class indicator (0100 S, 0010 M, 0001 L)
//   out1        out  LARGE actuator drive
//   out2        out  MEDIUM actuator drive
//   out3        out  SMALL actuator drive
//   class_code  out  [1:0] last sampled class (0 none .. 3 LARGE)
//   busy        out  high while firing or cooling down
//   reject      out  one-cycle pulse when a trigger is dropped
//   sort_count  out  [15:0] completed fires, wrapping
// -----------------------------------------------------------------------------
module sort_actuator_ctrl
    import sort_actuator_ctrl_pkg::*;
#(
    parameter int TICK_CNT  = 50_000_000,
    parameter int TH_LOW    = 5,
    parameter int TH_HIGH   = 30,
    parameter int STABLE_N  = 3,
    parameter int PULSE_CNT = 25_000_000,
    parameter int DB_CNT    = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] answer,
    input  logic        key_trig,
    output logic [3:0]  led,
    output logic        out1,
    output logic        out2,
    output logic        out3,
    output logic [1:0]  class_code,
    output logic        busy,
    output logic        reject,
    output logic [15:0] sort_count
);

    localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam int PW = (PULSE_CNT > 1) ? $clog2(PULSE_CNT) : 1;
    localparam int SW = $clog2(STABLE_N + 1);

    localparam logic [10:0] TH_LOW_V  = 11'(TH_LOW);
    localparam logic [10:0] TH_HIGH_V = 11'(TH_HIGH);

    function automatic cls_e classify(input logic [10:0] a);
        if (a <= TH_LOW_V) begin
            return CLS_SMALL;
        end else if (a <= TH_HIGH_V) begin
            return CLS_MEDIUM;
        end else begin
            return CLS_LARGE;
        end
    endfunction

    logic [TW-1:0] tick_cnt;
    logic          tick_p0;
    cls_e          cls_new_p0;
    cls_e          cls_p1;
    logic [SW-1:0] stab_p1;
    logic          class_valid;
    logic          trig;

    state_e        state;
    state_e        state_nx;
    logic [PW-1:0] pulse_cnt;
    logic          pulse_end;
    cls_e          fire_cls;

    // Stage p0: sample period timebase and classification of the live input.
    assign tick_p0    = (tick_cnt == TW'(TICK_CNT - 1));
    assign cls_new_p0 = classify(answer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_p0) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Stage p1: registered class and agreement count. A trigger arriving in
    // the tick cycle therefore sees the class from before that tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_p1  <= CLS_NONE;
            stab_p1 <= '0;
        end else if (tick_p0) begin
            cls_p1 <= cls_new_p0;
            if (cls_new_p0 != cls_p1) begin
                stab_p1 <= SW'(1);
            end else if (stab_p1 != SW'(STABLE_N)) begin
                stab_p1 <= stab_p1 + 1'b1;
            end
        end
    end

    assign class_valid = (stab_p1 >= SW'(STABLE_N));
    assign class_code  = cls_p1;
    assign led         = led_pattern(cls_p1);

    key_debounce #(
        .DB_CNT (DB_CNT)
    ) u_key_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_trig),
        .trig  (trig)
    );

    // Control stage: fire / cooldown sequencing.
    assign pulse_end = (pulse_cnt == PW'(PULSE_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        reject   = 1'b0;
        busy     = 1'b0;
        out1     = 1'b0;
        out2     = 1'b0;
        out3     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    if (class_valid) begin
                        state_nx = ST_FIRE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                busy   = 1'b1;
                reject = trig;
                out1   = (fire_cls == CLS_LARGE);
                out2   = (fire_cls == CLS_MEDIUM);
                out3   = (fire_cls == CLS_SMALL);
                if (pulse_end) begin
                    state_nx = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                busy   = 1'b1;
                reject = trig;
                if (pulse_end) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Phase counter restarts on every state change, so FIRE and COOLDOWN
    // each last exactly PULSE_CNT cycles. The class is frozen at entry so
    // later samples cannot redirect an active pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt  <= '0;
            fire_cls   <= CLS_NONE;
            sort_count <= '0;
        end else begin
            if (state != state_nx) begin
                pulse_cnt <= '0;
            end else if (state != ST_IDLE) begin
                pulse_cnt <= pulse_cnt + 1'b1;
            end
            if (state == ST_IDLE && state_nx == ST_FIRE) begin
                fire_cls <= cls_p1;
            end
            if (state == ST_FIRE && state_nx == ST_COOLDOWN) begin
                sort_count <= sort_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sort_actuator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sort_actuator_ctrl
// Directed bench for sort_actuator_ctrl with TICK_CNT=10, STABLE_N=3,
// PULSE_CNT=4, DB_CNT=5. Expectations follow the SORT_DEBOUNCE_EN setting
// of the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sort_actuator_ctrl;

    localparam int TICK  = 10;
    localparam int PULSE = 4;

`ifdef SORT_DEBOUNCE_EN
    localparam int LAT      = 7;   // edges from key drop until the press pulse
    localparam int N_LOW    = 8;
    localparam int D_PRE    = 1;
    localparam int D_NLOW   = 8;
    localparam int D_SECOND = 0;
    localparam int D_REJ    = 0;
`else
    localparam int LAT      = 2;
    localparam int N_LOW    = 8;
    localparam int D_PRE    = 6;
    localparam int D_NLOW   = 1;
    localparam int D_SECOND = 3;
    localparam int D_REJ    = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [10:0] answer;
    logic        key_trig;
    logic [3:0]  led;
    logic        out1;
    logic        out2;
    logic        out3;
    logic [1:0]  class_code;
    logic        busy;
    logic        reject;
    logic [15:0] sort_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int w_out1, w_out2, w_out3, w_busy, w_rej, w_first;
    int multi_hi = 0;

    sort_actuator_ctrl #(
        .TICK_CNT  (TICK),
        .TH_LOW    (5),
        .TH_HIGH   (30),
        .STABLE_N  (3),
        .PULSE_CNT (PULSE),
        .DB_CNT    (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .answer     (answer),
        .key_trig   (key_trig),
        .led        (led),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .class_code (class_code),
        .busy       (busy),
        .reject     (reject),
        .sort_count (sort_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_sample();
        step();
        while (cyc % TICK != 0) step();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        key_trig = 1'b1;
        answer   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_led", led, 4'b0000);
        check_eq("rst_class", class_code, 2'd0);
        check_eq("rst_outs", {out1, out2, out3}, 3'b000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_reject", reject, 1'b0);
        check_eq("rst_count", sort_count, 16'd0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Drives the key for n_watch cycles (low during [0,n_low) and, if
    // second_at > 0, again during [second_at, second_at+n_low)), optionally
    // changes answer at cycle ans_at, and tallies what the outputs did.
    task automatic watch(input int n_low, input int second_at, input int ans_at,
                         input logic [10:0] ans_new, input int n_watch);
        w_out1 = 0; w_out2 = 0; w_out3 = 0; w_busy = 0; w_rej = 0; w_first = -1;
        for (int i = 0; i < n_watch; i++) begin
            key_trig = !((i < n_low) ||
                         (second_at > 0 && i >= second_at && i < second_at + n_low));
            if (i == ans_at) answer = ans_new;
            step();
            if (out1) w_out1++;
            if (out2) w_out2++;
            if (out3) w_out3++;
            if (busy) w_busy++;
            if (reject) w_rej++;
            if (w_first < 0 && (out1 || out2 || out3)) w_first = i + 1;
            if (int'(out1) + int'(out2) + int'(out3) > 1) multi_hi++;
        end
        key_trig = 1'b1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        key_trig = 1'b1;
        answer   = '0;
        do_reset();

        // Stable SMALL, one press.
        answer = 11'd3;
        repeat (3) wait_sample();
        check_eq("A_class", class_code, 2'd1);
        check_eq("A_led", led, 4'b0100);
        watch(N_LOW, 0, -1, 11'd0, 24);
        check_eq("A_first_out", w_first, LAT + 1);
        check_eq("A_out3_cycles", w_out3, PULSE);
        check_eq("A_out12_cycles", w_out1 + w_out2, 0);
        check_eq("A_busy_cycles", w_busy, 2 * PULSE);
        check_eq("A_reject", w_rej, 0);
        check_eq("A_sort_count", sort_count, 16'd1);
        check_eq("A_busy_end", busy, 1'b0);

        // Threshold boundaries and stability restart.
        do_reset();
        answer = 11'd5;
        wait_sample();
        check_eq("B_class_5", class_code, 2'd1);
        repeat (2) wait_sample();
        answer = 11'd6;
        wait_sample();
        check_eq("B_class_6", class_code, 2'd2);
        check_eq("B_led_6", led, 4'b0010);
        answer = 11'd30;
        wait_sample();
        check_eq("B_class_30", class_code, 2'd2);
        watch(N_LOW, 0, -1, 11'd0, 24);
        check_eq("B_rej_after_6", w_rej, 1);
        check_eq("B_outs_after_6", w_out1 + w_out2 + w_out3, 0);
        answer = 11'd31;
        wait_sample();
        check_eq("B_class_31", class_code, 2'd3);
        check_eq("B_led_31", led, 4'b0001);
        watch(N_LOW, 0, -1, 11'd0, 24);
        check_eq("B_rej_after_31", w_rej, 1);
        check_eq("B_outs_after_31", w_out1 + w_out2 + w_out3, 0);
        watch(N_LOW, 0, -1, 11'd0, 24);
        check_eq("B_out1_fire", w_out1, PULSE);
        check_eq("B_rej_fire", w_rej, 0);
        check_eq("B_sort_count", sort_count, 16'd1);

        // Unstable LARGE: press is rejected.
        do_reset();
        answer = 11'd40;
        repeat (2) wait_sample();
        check_eq("C_class", class_code, 2'd3);
        watch(N_LOW, 0, -1, 11'd0, 24);
        check_eq("C_reject", w_rej, 1);
        check_eq("C_outs", w_out1 + w_out2 + w_out3, 0);
        check_eq("C_busy", w_busy, 0);
        check_eq("C_sort_count", sort_count, 16'd0);

        // Class change and second press while firing LARGE.
        do_reset();
        answer = 11'd40;
        repeat (3) wait_sample();
        repeat (D_PRE) step();
        watch(D_NLOW, D_SECOND, 0, 11'd3, 24);
        check_eq("D_out1_cycles", w_out1, PULSE);
        check_eq("D_out23_cycles", w_out2 + w_out3, 0);
        check_eq("D_reject", w_rej, D_REJ);
        check_eq("D_sort_count", sort_count, 16'd1);
        check_eq("D_class_after", class_code, 2'd1);

        // Reset in the middle of a pulse.
        do_reset();
        answer = 11'd40;
        repeat (3) wait_sample();
        key_trig = 1'b0;
        repeat (LAT + 2) step();
        check_eq("E_out1_before", out1, 1'b1);
        check_eq("E_busy_before", busy, 1'b1);
        #4;
        rst_n = 1'b0;
        #1;
        check_eq("E_out1_async", out1, 1'b0);
        check_eq("E_busy_async", busy, 1'b0);
        check_eq("E_class_async", class_code, 2'd0);
        key_trig = 1'b1;
        do_reset();
        repeat (3) step();
        check_eq("E_busy_after", busy, 1'b0);
        check_eq("E_out1_after", out1, 1'b0);
        check_eq("E_sort_after", sort_count, 16'd0);

        // Short key presses.
`ifdef SORT_DEBOUNCE_EN
        do_reset();
        watch(3, 0, -1, 11'd0, 16);
        check_eq("F_short_press", w_rej, 0);
        do_reset();
        watch(6, 0, -1, 11'd0, 20);
        check_eq("F_long_press", w_rej, 1);
`else
        do_reset();
        watch(3, 0, -1, 11'd0, 16);
        check_eq("F_short_press", w_rej, 1);
`endif

        check_eq("one_hot_outputs", multi_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
